button_debounce_bank: RTL and testbench
=======================================

// Module: button_debounce_bank
// PURPOSE
//  N-channel push-button debouncer: per-channel 2-FF synchroniser, programmable debounce
//  filter, press/release pulses and optional hold-to-repeat pulses.
//  Sits between raw board button pins and UI/game-control FSMs.
//  Replaces per-button debouncer instances with one parametrised bank.
// PARAMETERS
//  N_CH            4      number of independent button channels (>=1)
//  ACTIVE_LOW      1      1: pin low = pressed (input inverted); 0: pin high = pressed
//  DEBOUNCE_CYCLES 65536  consecutive cycles of a new level needed to accept it (>=2)
//  REPEAT_EN       1      1: generate pb_repeat while held; 0: pb_repeat tied 0
//  HOLD_CYCLES     25000000  cycles held before first repeat pulse (>=1)
//  REPEAT_CYCLES   5000000   cycles between subsequent repeat pulses (>=1)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      one clock; reset is synchronous and active-high
//  pb         in   N_CH   raw asynchronous glitchy button pins
//  pb_state   out  N_CH   debounced level, 1 = pressed
//  pb_down    out  N_CH   1-cycle pulse on accepted press
//  pb_up      out  N_CH   1-cycle pulse on accepted release
//  pb_repeat  out  N_CH   1-cycle pulse per auto-repeat tick while held
// BEHAVIOUR
//  - Channels fully independent; no cross-channel interaction or priority.
//  - Reset: sync FFs load the released level, debounce/hold counters 0, all outputs 0.
//    No spurious press after reset; a button held through reset reports a press per
//    normal latency, counted from the first post-reset edge.
//  - Sync: s0 <= pb^ACTIVE_LOW-normalised, s1 <= s0. idle = (s1 == pb_state).
//  - Debounce counter, width $clog2(DEBOUNCE_CYCLES): idle -> cleared to 0;
//    not idle and cnt != DEBOUNCE_CYCLES-1 -> cnt+1;
//    not idle and cnt == DEBOUNCE_CYCLES-1 -> pb_state toggles, cnt <= 0.
//  - Any glitch returning s1 to pb_state before terminal count clears cnt; no pulse.
//  - Latency: pin level first sampled at edge 1 -> pb_state changes at edge DEBOUNCE_CYCLES+2.
//  - pb_down / pb_up registered: high exactly in the first cycle pb_state reads 1 / 0
//    after a toggle; never both high; never high without a pb_state change.
//  - Hold counter: 0 while pb_state==0; increments each cycle pb_state==1, saturating
//    logic not needed (reloads on repeat). With E = edge where pb_state rises:
//    pb_repeat high in cycle after edge E+HOLD_CYCLES, then every REPEAT_CYCLES.
//    No pb_repeat coincident with pb_down.
//  - Release (pb_state falls) clears hold counter in the same edge; no repeat pulse
//    in or after the pb_up cycle, even if the release coincides with a terminal count
//    (release wins).
//  - REPEAT_EN=0: hold logic not generated, pb_repeat constant 0.
//  - rst asserted mid-debounce or mid-hold: all state discarded next edge; no pulses
//    emitted during or in the cycle after reset.
// STRUCTURE
//  - Package button_debounce_pkg: default parameter constants, clog2-based width
//    function, sanity-check macro for DEBOUNCE_CYCLES>=2, HOLD/REPEAT>=1.
//  - Sub-module button_debounce_channel: one channel (sync, debounce counter,
//    pb_state/pulse regs, hold/repeat counter); top instantiates N_CH copies
//    via generate loop and concatenates outputs.
// TESTING (N_CH=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5)
//  1 rst 3 cycles, pb=2'b11 -> all outputs 0 during and after reset for 20 cycles.
//  2 pb[0] 1->0 sampled edge 1, held -> pb_state[0]=1 and pb_down[0]=1 after edge 6,
//    pb_down[0] 0 after edge 7; channel 1 unchanged.
//  3 pb[0] low 3 cycles then high (bounce) -> no pb_state change, no pulses; then
//    stable low -> press accepted 6 edges after the final low transition is sampled.
//  4 hold pb[0] low 30 cycles after press at edge E -> pb_repeat[0] pulses after
//    edges E+10, E+15, E+20, E+25; exactly 1 cycle each.
//  5 release after press (stable high) -> pb_up[0]=1 one cycle, pb_state[0]=0,
//    no further pb_repeat; both channels pressed same cycle -> identical timing.
//  6 rst asserted 2 cycles into a pending press -> no pulse; press re-qualifies
//    with full 6-edge latency after rst deasserts; REPEAT_EN=0 build -> pb_repeat 0.

Source files
------------

// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_pkg
// Description : Shared defaults, counter-width helpers and parameter check.
// Revision    : 1.0 - initial release
// ============================================================================
package button_debounce_pkg;

    localparam int unsigned c_DEF_N_CH            = 4;
    localparam int unsigned c_DEF_ACTIVE_LOW      = 1;
    localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 65536;
    localparam int unsigned c_DEF_REPEAT_EN       = 1;
    localparam int unsigned c_DEF_HOLD_CYCLES     = 25000000;
    localparam int unsigned c_DEF_REPEAT_CYCLES   = 5000000;

    // Width of a counter that runs 0 .. max_count-1, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

`define BUTTON_DEBOUNCE_PARAM_CHECK(DB, HOLD, REP) \
    if (((DB) < 2) || ((HOLD) < 1) || ((REP) < 1)) begin : g_param_check_fail \
        $error("button_debounce: DEBOUNCE_CYCLES must be >=2, HOLD/REPEAT_CYCLES >=1"); \
    end

`default_nettype wire

// File: rtl/button_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_channel
// Description : One button: 2-FF sync, debounce filter, edge pulses, auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW      = c_DEF_ACTIVE_LOW,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_EN       = c_DEF_REPEAT_EN,
    parameter int unsigned HOLD_CYCLES     = c_DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = c_DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic pb_state,
    output logic pb_down,
    output logic pb_up,
    output logic pb_repeat
);

    localparam int unsigned       c_DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_TERM = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              c_INVERT  = (ACTIVE_LOW != 0);

    logic              r_s0;
    logic              r_s1;
    logic              r_state;
    logic              r_down;
    logic              r_up;
    logic [c_DB_W-1:0] r_db_cnt;

    logic w_idle;
    logic w_toggle;
    logic w_release;

    assign w_idle    = (r_s1 == r_state);
    assign w_toggle  = !w_idle && (r_db_cnt == c_DB_TERM);
    assign w_release = w_toggle && r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0     <= 1'b0;
            r_s1     <= 1'b0;
            r_state  <= 1'b0;
            r_down   <= 1'b0;
            r_up     <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_s0   <= pb ^ c_INVERT;
            r_s1   <= r_s0;
            r_down <= w_toggle && !r_state;
            r_up   <= w_release;
            if (w_idle) begin
                r_db_cnt <= '0;
            end else if (w_toggle) begin
                r_db_cnt <= '0;
                r_state  <= ~r_state;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign pb_state = r_state;
    assign pb_down  = r_down;
    assign pb_up    = r_up;

    if (REPEAT_EN != 0) begin : g_repeat
        localparam int unsigned         c_HOLD_W   = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));
        localparam logic [c_HOLD_W-1:0] c_HOLD_TERM = c_HOLD_W'(HOLD_CYCLES - 1);
        localparam logic [c_HOLD_W-1:0] c_REP_TERM  = c_HOLD_W'(REPEAT_CYCLES - 1);

        logic [c_HOLD_W-1:0] r_hold_cnt;
        logic                r_rep_phase;
        logic                r_repeat;
        logic                w_hit;

        // First terminal is the initial hold delay, later ones the repeat period.
        assign w_hit = (r_hold_cnt == (r_rep_phase ? c_REP_TERM : c_HOLD_TERM));

        always_ff @(posedge clk) begin
            if (rst || !r_state || w_release) begin
                r_hold_cnt  <= '0;
                r_rep_phase <= 1'b0;
                r_repeat    <= 1'b0;
            end else if (w_hit) begin
                r_hold_cnt  <= '0;
                r_rep_phase <= 1'b1;
                r_repeat    <= 1'b1;
            end else begin
                r_hold_cnt  <= r_hold_cnt + 1'b1;
                r_repeat    <= 1'b0;
            end
        end

        assign pb_repeat = r_repeat;
    end else begin : g_no_repeat
        assign pb_repeat = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/button_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_bank
// Description : N independent debounced push-button channels.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_bank
    import button_debounce_pkg::*;
#(
    parameter int unsigned N_CH            = c_DEF_N_CH,
    parameter int unsigned ACTIVE_LOW      = c_DEF_ACTIVE_LOW,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_EN       = c_DEF_REPEAT_EN,
    parameter int unsigned HOLD_CYCLES     = c_DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = c_DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pb,
    output logic [N_CH-1:0] pb_state,
    output logic [N_CH-1:0] pb_down,
    output logic [N_CH-1:0] pb_up,
    output logic [N_CH-1:0] pb_repeat
);

    `BUTTON_DEBOUNCE_PARAM_CHECK(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_debounce_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .pb        (pb[i]),
            .pb_state  (pb_state[i]),
            .pb_down   (pb_down[i]),
            .pb_up     (pb_up[i]),
            .pb_repeat (pb_repeat[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce_bank
// Description : Directed self-checking bench, repeat and no-repeat builds side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pb;

    logic [1:0] pb_state, pb_down, pb_up, pb_repeat;
    logic [1:0] nr_state, nr_down, nr_up, nr_repeat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    button_debounce_bank #(
        .N_CH(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst), .pb(pb),
        .pb_state(pb_state), .pb_down(pb_down), .pb_up(pb_up), .pb_repeat(pb_repeat)
    );

    button_debounce_bank #(
        .N_CH(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(0), .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
    ) dut_norep (
        .clk(clk), .rst(rst), .pb(pb),
        .pb_state(nr_state), .pb_down(nr_down), .pb_up(nr_up), .pb_repeat(nr_repeat)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] es, input logic [1:0] ed,
                       input logic [1:0] eu, input logic [1:0] er);
        tests++;
        assert ({pb_state, pb_down, pb_up, pb_repeat} === {es, ed, eu, er}) else begin
            fails++;
            $error("FAIL %s: state/down/up/rep observed %b/%b/%b/%b expected %b/%b/%b/%b",
                   tag, pb_state, pb_down, pb_up, pb_repeat, es, ed, eu, er);
        end
        tests++;
        assert ({nr_state, nr_down, nr_up, nr_repeat} === {es, ed, eu, 2'b00}) else begin
            fails++;
            $error("FAIL %s_norep: state/down/up/rep observed %b/%b/%b/%b expected %b/%b/%b/00",
                   tag, nr_state, nr_down, nr_up, nr_repeat, es, ed, eu);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pb  = 2'b11;

        // Reset and quiet idle with both pins released (high).
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("post_reset_idle", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Channel 0 press; accepted at edge 6, then held through several repeats.
        pb = 2'b10;
        tick(5);
        chk("press_pending", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk("press_accept", 2'b01, 2'b01, 2'b00, 2'b00);
        tick(1);
        chk("press_down_clear", 2'b01, 2'b00, 2'b00, 2'b00);
        for (int k = 2; k <= 40; k++) begin
            if (k == 29) pb = 2'b11;
            tick(1);
            if (k < 34)
                chk("hold", 2'b01, 2'b00, 2'b00,
                    (k >= 10 && ((k - 10) % 5) == 0) ? 2'b01 : 2'b00);
            else if (k == 34)
                chk("release", 2'b00, 2'b00, 2'b01, 2'b00);
            else
                chk("released_idle", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Three-cycle bounce falls one short of the filter length.
        pb = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("bounce_low", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        pb = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("bounce_settle", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        pb = 2'b10;
        tick(5);
        chk("stable_pending", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk("stable_accept", 2'b01, 2'b01, 2'b00, 2'b00);
        tick(1);
        chk("stable_held", 2'b01, 2'b00, 2'b00, 2'b00);
        pb = 2'b11;
        tick(5);
        chk("short_release_pending", 2'b01, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk("short_release", 2'b00, 2'b00, 2'b01, 2'b00);
        tick(1);
        chk("short_release_clear", 2'b00, 2'b00, 2'b00, 2'b00);

        // Both channels together must track identically.
        pb = 2'b00;
        tick(5);
        chk("both_pending", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk("both_accept", 2'b11, 2'b11, 2'b00, 2'b00);
        tick(1);
        chk("both_held", 2'b11, 2'b00, 2'b00, 2'b00);
        pb = 2'b11;
        tick(5);
        chk("both_release_pending", 2'b11, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk("both_release", 2'b00, 2'b00, 2'b11, 2'b00);
        tick(1);
        chk("both_release_clear", 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset two cycles into a pending press discards it; full latency after.
        pb = 2'b10;
        tick(2);
        chk("rst_pend_pre", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        tick(1);
        chk("rst_pend_rst1", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk("rst_pend_rst2", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("rst_pend_requal", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        tick(1);
        chk("rst_pend_accept", 2'b01, 2'b01, 2'b00, 2'b00);

        // Reset just before the first repeat tick drops state and the repeat.
        tick(8);
        chk("rst_hold_pre", 2'b01, 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        tick(1);
        chk("rst_hold_rst1", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk("rst_hold_rst2", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("rst_hold_requal", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        tick(1);
        chk("rst_hold_accept", 2'b01, 2'b01, 2'b00, 2'b00);
        pb = 2'b11;
        tick(5);
        chk("final_release_pending", 2'b01, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk("final_release", 2'b00, 2'b00, 2'b01, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
